// File: rtl/xinlv_pkg.sv
`default_nettype none
// ============================================================================
// xinlv_pkg : shared FSM encoding, ASCII constants and frame byte table
// Rev 1.0   : frame length follows XINLV_TX_CRLF_EN
// ============================================================================
package xinlv_pkg;

   typedef enum logic [4:0] {
      ST_IDLE  = 5'b00001,
      ST_CONV  = 5'b00010,
      ST_SEND  = 5'b00100,
      ST_ACK   = 5'b01000,
      ST_DONEW = 5'b10000
   } state_t;

   localparam logic [7:0] HDR_B   = 8'h42;
   localparam logic [7:0] HDR_P   = 8'h50;
   localparam logic [7:0] HDR_M   = 8'h4D;
   localparam logic [7:0] ASCII_0 = 8'h30;
   localparam logic [7:0] CR      = 8'h0D;
   localparam logic [7:0] LF      = 8'h0A;

   localparam int FRAME_LEN_BASE = 5;
   localparam int FRAME_LEN_CRLF = 7;
`ifdef XINLV_TX_CRLF_EN
   localparam int FRAME_LEN = FRAME_LEN_CRLF;
`else
   localparam int FRAME_LEN = FRAME_LEN_BASE;
`endif

   function automatic logic [7:0] frame_byte(input logic [2:0] idx,
                                             input logic [3:0] tens,
                                             input logic [3:0] ones);
      logic [7:0] b;
      case (idx)
         3'd0:    b = HDR_B;
         3'd1:    b = HDR_P;
         3'd2:    b = HDR_M;
         3'd3:    b = ASCII_0 + {4'd0, tens};
         3'd4:    b = ASCII_0 + {4'd0, ones};
         3'd5:    b = CR;
         3'd6:    b = LF;
         default: b = HDR_B;
      endcase
      return b;
   endfunction

endpackage
`default_nettype wire

// File: rtl/xinlv_bin2dec_seq.sv
`default_nettype none
// ============================================================================
// xinlv_bin2dec_seq : iterative subtract-by-10 converter, 0..99 -> tens/ones
// Rev 1.0
// ============================================================================
module xinlv_bin2dec_seq (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [6:0] value,
   output logic       done,
   output logic [3:0] tens,
   output logic [3:0] ones
);

   logic [6:0] rem_r;
   logic       busy_r;

   // done marks the final cycle; ones is captured on that same edge
   assign done = busy_r && (rem_r < 7'd10);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rem_r  <= 7'd0;
         busy_r <= 1'b0;
         tens   <= 4'd0;
         ones   <= 4'd0;
      end else if (start) begin
         rem_r  <= value;
         busy_r <= 1'b1;
         tens   <= 4'd0;
      end else if (busy_r) begin
         if (rem_r >= 7'd10) begin
            rem_r <= rem_r - 7'd10;
            tens  <= tens + 4'd1;
         end else begin
            ones   <= rem_r[3:0];
            busy_r <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/xinlv_tx_frame.sv
`default_nettype none
// ============================================================================
// xinlv_tx_frame : sends "BPM"+two ASCII digits to uart_tx, byte by byte
// Rev 1.0        : XINLV_TX_CRLF_EN appends CR LF to the frame
// ============================================================================
module xinlv_tx_frame
   import xinlv_pkg::*;
#(
   parameter int TIMEOUT_CYC = 1024,
   parameter int CLAMP_MAX   = 99
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] xinlv,
   input  logic       send_req,
   input  logic       tx_busy,
   output logic [7:0] data_tx,
   output logic       tx_start,
   output logic       frame_busy,
   output logic       frame_done,
   output logic       frame_err,
   output logic       clamped
);

   localparam int           TW        = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TW-1:0] TCNT_LAST = TW'(TIMEOUT_CYC - 1);
   localparam logic [6:0]   CLAMP_V   = 7'(CLAMP_MAX);
   localparam logic [2:0]   LAST_IDX  = 3'(FRAME_LEN - 1);

   state_t        state_r;
   logic [2:0]    idx_r;
   logic [TW-1:0] tcnt_r;
   logic          tx_busy_r;
   logic          accept;
   logic          over;
   logic [6:0]    val_clamped;
   logic          conv_done;
   logic [3:0]    tens;
   logic [3:0]    ones;

   assign accept      = (state_r == ST_IDLE) && send_req;
   assign over        = xinlv > {1'b0, CLAMP_V};
   assign val_clamped = over ? CLAMP_V : xinlv[6:0];

   xinlv_bin2dec_seq u_b2d (
      .clk   (clk),
      .rst_n (rst_n),
      .start (accept),
      .value (val_clamped),
      .done  (conv_done),
      .tens  (tens),
      .ones  (ones)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= ST_IDLE;
         idx_r      <= 3'd0;
         tcnt_r     <= '0;
         tx_busy_r  <= 1'b0;
         data_tx    <= 8'd0;
         tx_start   <= 1'b0;
         frame_busy <= 1'b0;
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
         clamped    <= 1'b0;
      end else begin
         tx_start   <= 1'b0;
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
         tx_busy_r  <= tx_busy;
         case (state_r)
            ST_IDLE: begin
               if (send_req) begin
                  clamped    <= over;
                  frame_busy <= 1'b1;
                  idx_r      <= 3'd0;
                  state_r    <= ST_CONV;
               end
            end
            ST_CONV: begin
               if (conv_done)
                  state_r <= ST_SEND;
            end
            ST_SEND: begin
               if (!tx_busy) begin
                  data_tx  <= frame_byte(idx_r, tens, ones);
                  tx_start <= 1'b1;
                  tcnt_r   <= '0;
                  state_r  <= ST_ACK;
               end
            end
            ST_ACK: begin
               // uart_tx must acknowledge the strobe by raising busy
               if (tx_busy) begin
                  state_r <= ST_DONEW;
               end else if (tcnt_r == TCNT_LAST) begin
                  frame_err  <= 1'b1;
                  frame_busy <= 1'b0;
                  state_r    <= ST_IDLE;
               end else begin
                  tcnt_r <= tcnt_r + TW'(1);
               end
            end
            ST_DONEW: begin
               if (tx_busy_r && !tx_busy) begin
                  if (idx_r == LAST_IDX) begin
                     frame_done <= 1'b1;
                     frame_busy <= 1'b0;
                     state_r    <= ST_IDLE;
                  end else begin
                     idx_r   <= idx_r + 3'd1;
                     state_r <= ST_SEND;
                  end
               end
            end
            default: state_r <= ST_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_xinlv_tx_frame.sv
`default_nettype none
// ============================================================================
// tb_xinlv_tx_frame : directed bench with a simple uart_tx busy model
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_xinlv_tx_frame;

   localparam int TB_TIMEOUT = 1024;
   localparam int BUSY_CYC   = 20;
`ifdef XINLV_TX_CRLF_EN
   localparam int NB = 7;
`else
   localparam int NB = 5;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] xinlv = 8'd0;
   logic       send_req = 1'b0;
   logic       tx_busy = 1'b0;
   logic [7:0] data_tx;
   logic       tx_start;
   logic       frame_busy;
   logic       frame_done;
   logic       frame_err;
   logic       clamped;

   int errors = 0;
   int checks = 0;
   logic [7:0] cap [0:127];
   int cap_n = 0;
   int done_cnt = 0;
   int err_cnt = 0;
   bit model_en = 1'b1;
   int busy_cnt = 0;

   xinlv_tx_frame #(.TIMEOUT_CYC(TB_TIMEOUT), .CLAMP_MAX(99)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .xinlv      (xinlv),
      .send_req   (send_req),
      .tx_busy    (tx_busy),
      .data_tx    (data_tx),
      .tx_start   (tx_start),
      .frame_busy (frame_busy),
      .frame_done (frame_done),
      .frame_err  (frame_err),
      .clamped    (clamped)
   );

   always #5 clk = ~clk;

   // uart_tx stand-in: logs every strobe, holds busy for BUSY_CYC cycles
   always begin
      @(posedge clk);
      #1;
      if (tx_start === 1'b1) begin
         if (cap_n < 128) cap[cap_n] = data_tx;
         cap_n++;
      end
      if (busy_cnt > 0) begin
         busy_cnt--;
         if (busy_cnt == 0) tx_busy = 1'b0;
      end else if (tx_start === 1'b1 && model_en) begin
         tx_busy  = 1'b1;
         busy_cnt = BUSY_CYC;
      end
   end

   always @(negedge clk) begin
      if (frame_done === 1'b1) done_cnt++;
      if (frame_err === 1'b1) err_cnt++;
   end

   task automatic wait_idle_bus();
      int n = 0;
      while (tx_busy !== 1'b0 && n < 200) begin @(negedge clk); n++; end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({data_tx, tx_start, frame_busy, frame_done, frame_err, clamped} !== 13'd0)
         $display("FAIL reset_outputs: got %h required 0",
                  {data_tx, tx_start, frame_busy, frame_done, frame_err, clamped});
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (frame_busy !== 1'b0 || tx_start !== 1'b0) begin
         errors++;
         $display("FAIL idle_after_reset: busy=%b start=%b required 0 0", frame_busy, tx_start);
      end
   endtask

   task automatic run_frame(input logic [7:0] v, input int et, input int eo,
                            input logic ec, input string nm);
      int base, d0, lat, n;
      logic [7:0] exp_b [0:6];
      exp_b[0] = 8'h42; exp_b[1] = 8'h50; exp_b[2] = 8'h4D;
      exp_b[3] = 8'(8'h30 + et); exp_b[4] = 8'(8'h30 + eo);
      exp_b[5] = 8'h0D; exp_b[6] = 8'h0A;
      wait_idle_bus();
      base = cap_n; d0 = done_cnt;
      @(negedge clk); xinlv = v; send_req = 1'b1;
      @(negedge clk); send_req = 1'b0;
      checks++;
      if (frame_busy !== 1'b1) begin
         errors++; $display("FAIL %s busy_on_accept: got %b required 1", nm, frame_busy);
      end
      checks++;
      if (clamped !== ec) begin
         errors++; $display("FAIL %s clamped: got %b required %b", nm, clamped, ec);
      end
      lat = 0;
      while (tx_start !== 1'b1 && lat < 60) begin @(negedge clk); lat++; end
      checks++;
      if (lat != et + 2) begin
         errors++; $display("FAIL %s first_start_latency: got %0d required %0d", nm, lat, et + 2);
      end
      n = 0;
      while (frame_done !== 1'b1 && frame_err !== 1'b1 && n < 3000) begin
         @(negedge clk); n++;
      end
      checks++;
      if (frame_done !== 1'b1) begin
         errors++; $display("FAIL %s frame_done: got %b required 1", nm, frame_done);
      end
      checks++;
      if (frame_busy !== 1'b0 || clamped !== ec) begin
         errors++;
         $display("FAIL %s end_state: busy=%b clamped=%b required 0 %b", nm, frame_busy, clamped, ec);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (cap_n - base != NB) begin
         errors++; $display("FAIL %s byte_count: got %0d required %0d", nm, cap_n - base, NB);
      end
      for (int i = 0; i < NB; i++) begin
         checks++;
         if (cap[base + i] !== exp_b[i]) begin
            errors++;
            $display("FAIL %s byte%0d: got %h required %h", nm, i, cap[base + i], exp_b[i]);
         end
      end
      checks++;
      if (done_cnt - d0 != 1) begin
         errors++; $display("FAIL %s done_pulses: got %0d required 1", nm, done_cnt - d0);
      end
   endtask

   task automatic test_ignore_during_frame();
      int base, d0, n;
      bit dropped = 1'b0;
      wait_idle_bus();
      base = cap_n; d0 = done_cnt;
      @(negedge clk); xinlv = 8'd31; send_req = 1'b1;
      @(negedge clk); send_req = 1'b0;
      n = 0;
      while (cap_n < base + 3 && n < 1000) begin @(negedge clk); n++; end
      xinlv = 8'd9; send_req = 1'b1;
      @(negedge clk); send_req = 1'b0;
      n = 0;
      while (frame_done !== 1'b1 && n < 3000) begin
         if (frame_busy !== 1'b1) dropped = 1'b1;
         @(negedge clk); n++;
      end
      checks++;
      if (dropped) begin
         errors++; $display("FAIL ignore busy_held: got dropped required held");
      end
      repeat (60) @(negedge clk);
      checks++;
      if (cap_n - base != NB) begin
         errors++; $display("FAIL ignore start_count: got %0d required %0d", cap_n - base, NB);
      end
      checks++;
      if (done_cnt - d0 != 1 || frame_busy !== 1'b0) begin
         errors++;
         $display("FAIL ignore not_queued: done=%0d busy=%b required 1 0", done_cnt - d0, frame_busy);
      end
      checks++;
      if (cap[base + 3] !== 8'h33 || cap[base + 4] !== 8'h31) begin
         errors++;
         $display("FAIL ignore digits: got %h %h required 33 31", cap[base + 3], cap[base + 4]);
      end
   endtask

   task automatic test_timeout();
      int base, e0, d0, n, c;
      wait_idle_bus();
      model_en = 1'b0;
      base = cap_n; e0 = err_cnt; d0 = done_cnt;
      @(negedge clk); xinlv = 8'd45; send_req = 1'b1;
      @(negedge clk); send_req = 1'b0;
      n = 0;
      while (tx_start !== 1'b1 && n < 60) begin @(negedge clk); n++; end
      c = 0;
      while (frame_err !== 1'b1 && c < TB_TIMEOUT + 50) begin @(negedge clk); c++; end
      checks++;
      if (c != TB_TIMEOUT) begin
         errors++; $display("FAIL timeout cycles_to_err: got %0d required %0d", c, TB_TIMEOUT);
      end
      checks++;
      if (frame_busy !== 1'b0 || frame_done !== 1'b0) begin
         errors++;
         $display("FAIL timeout end_state: busy=%b done=%b required 0 0", frame_busy, frame_done);
      end
      repeat (100) @(negedge clk);
      checks++;
      if (cap_n - base != 1 || cap[base] !== 8'h42) begin
         errors++;
         $display("FAIL timeout starts: got %0d first=%h required 1 42", cap_n - base, cap[base]);
      end
      checks++;
      if (err_cnt - e0 != 1 || done_cnt != d0) begin
         errors++;
         $display("FAIL timeout pulses: err=%0d done=%0d required 1 0", err_cnt - e0, done_cnt - d0);
      end
      model_en = 1'b1;
   endtask

   task automatic test_reset_mid_frame();
      int base, n, c0;
      wait_idle_bus();
      base = cap_n;
      @(negedge clk); xinlv = 8'd200; send_req = 1'b1;
      @(negedge clk); send_req = 1'b0;
      n = 0;
      while (cap_n < base + 4 && n < 1000) begin @(negedge clk); n++; end
      checks++;
      if (cap_n < base + 4) begin
         errors++; $display("FAIL rstmid reach_byte3: got %0d starts required 4", cap_n - base);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({data_tx, tx_start, frame_busy, frame_done, frame_err, clamped} !== 13'd0) begin
         errors++;
         $display("FAIL rstmid outputs: got %h required 0",
                  {data_tx, tx_start, frame_busy, frame_done, frame_err, clamped});
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      c0 = cap_n;
      repeat (40) @(negedge clk);
      checks++;
      if (cap_n != c0) begin
         errors++; $display("FAIL rstmid no_restart: got %0d starts required 0", cap_n - c0);
      end
      run_frame(8'd88, 8, 8, 1'b0, "after_reset");
   endtask

   initial begin
      test_reset();
      run_frame(8'd72, 7, 2, 1'b0, "bpm72");
      run_frame(8'd5, 0, 5, 1'b0, "bpm5");
      run_frame(8'd0, 0, 0, 1'b0, "bpm0");
      run_frame(8'd150, 9, 9, 1'b1, "bpm150");
      run_frame(8'd99, 9, 9, 1'b0, "bpm99");
      test_ignore_during_frame();
      test_timeout();
      test_reset_mid_frame();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
